prco_pipe_ctrl: RTL

Multi-cycle sequencer for the PRCO core, sitting between instruction fetch, decoder, ALU and data RAM. It issues one-cycle enables to each stage in order and owns the program counter. It consumes the ALU's write-back, RAM and branch strobes to choose the next PC and the next stage. It also detects halt and ALU protocol errors.

---
 rtl/prco_pipe_ctrl_pkg.sv | 30 +++
 rtl/prco_pipe_ctrl_if.sv | 43 ++++
 rtl/prco_pipe_ctrl_perf_cnt.sv | 42 ++++
 rtl/prco_pipe_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/prco_pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// prco_pipe_ctrl_pkg
// Shared definitions for the PRCO pipeline sequencer: PC width and reset value,
// the 4-bit sequencer state encoding, and the modulo PC increment helper.
// -----------------------------------------------------------------------------
package prco_pipe_ctrl_pkg;

   localparam int unsigned PC_W = 32'd16;

   typedef logic [PC_W-1:0] pc_t;

   localparam pc_t PC_RESET = 16'h0000;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_FWAIT  = 4'd2,
      S_DECODE = 4'd3,
      S_EXEC   = 4'd4,
      S_ALU    = 4'd5,
      S_MEM    = 4'd6,
      S_HALT   = 4'd7
   } state_e;

   // 16-bit modulo increment: 16'hFFFF wraps to 16'h0000 silently.
   function automatic pc_t pc_inc(input pc_t pc);
      return pc + 16'd1;
   endfunction

endpackage

// File: rtl/prco_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// prco_pipe_if
// Bundle of the sequencer's stage handshakes.
//   master : the sequencer (drives q_*, samples i_*)
//   slave  : fetch/decode/ALU/RAM side (drives i_*, samples q_*)
// Signals:
//   i_run, i_imem_rdy, i_dec_halt, i_alu_ce_reg, i_alu_ce_ram, i_alu_branch,
//   i_alu_result[15:0], i_ram_done  -> into the sequencer
//   q_pc[15:0], q_ce_fetch, q_ce_dec, q_ce_alu, q_busy, q_halted, q_err
//                                   -> out of the sequencer
// -----------------------------------------------------------------------------
interface prco_pipe_if;

   logic                     i_run;
   logic                     i_imem_rdy;
   logic                     i_dec_halt;
   logic                     i_alu_ce_reg;
   logic                     i_alu_ce_ram;
   logic                     i_alu_branch;
   prco_pipe_ctrl_pkg::pc_t  i_alu_result;
   logic                     i_ram_done;

   prco_pipe_ctrl_pkg::pc_t  q_pc;
   logic                     q_ce_fetch;
   logic                     q_ce_dec;
   logic                     q_ce_alu;
   logic                     q_busy;
   logic                     q_halted;
   logic                     q_err;

   modport master (
      input  i_run, i_imem_rdy, i_dec_halt, i_alu_ce_reg, i_alu_ce_ram,
             i_alu_branch, i_alu_result, i_ram_done,
      output q_pc, q_ce_fetch, q_ce_dec, q_ce_alu, q_busy, q_halted, q_err
   );

   modport slave (
      output i_run, i_imem_rdy, i_dec_halt, i_alu_ce_reg, i_alu_ce_ram,
             i_alu_branch, i_alu_result, i_ram_done,
      input  q_pc, q_ce_fetch, q_ce_dec, q_ce_alu, q_busy, q_halted, q_err
   );

endinterface

// File: rtl/prco_pipe_ctrl_perf_cnt.sv
// -----------------------------------------------------------------------------
// prco_perf_cnt
// Busy-cycle and retired-instruction counters for the PRCO sequencer.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_clr            synchronous clear (sequencer leaving S_IDLE)
//   i_busy           count this cycle as busy
//   i_retire         one instruction retires at this edge
//   q_cyc_cnt[31:0]  busy cycles since last clear (wraps mod 2^32)
//   q_ret_cnt[31:0]  retired instructions since last clear (wraps mod 2^32)
// -----------------------------------------------------------------------------
module prco_perf_cnt (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clr,
   input  logic        i_busy,
   input  logic        i_retire,
   output logic [31:0] q_cyc_cnt,
   output logic [31:0] q_ret_cnt
);

   logic [31:0] r_cyc_cnt;
   logic [31:0] r_ret_cnt;

   // Both counters clear together on run start and otherwise wrap freely.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cyc_cnt <= 32'd0;
         r_ret_cnt <= 32'd0;
      end else if (i_clr) begin
         r_cyc_cnt <= 32'd0;
         r_ret_cnt <= 32'd0;
      end else begin
         r_cyc_cnt <= r_cyc_cnt + {31'd0, i_busy};
         r_ret_cnt <= r_ret_cnt + {31'd0, i_retire};
      end
   end

   assign q_cyc_cnt = r_cyc_cnt;
   assign q_ret_cnt = r_ret_cnt;

endmodule

// File: rtl/prco_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// prco_pipe_ctrl
// Multi-cycle sequencer for the PRCO core. Walks each instruction through
// FETCH -> FWAIT -> DECODE -> EXEC -> ALU (-> MEM), pulsing one stage enable
// per step, owns the program counter and flags halt / ALU protocol errors.
// Ports:
//   i_clk, i_rst_n   core clock, async active-low reset
//   bus (master)     stage handshakes, PC and status (see prco_pipe_if)
//   q_cyc_cnt/q_ret_cnt [31:0]  performance counters, only when the macro
//                    PRCO_PIPE_PERF_EN is defined
// -----------------------------------------------------------------------------
module prco_pipe_ctrl
   import prco_pipe_ctrl_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst_n,
   prco_pipe_if.master  bus
`ifdef PRCO_PIPE_PERF_EN
   ,
   output logic [31:0]  q_cyc_cnt,
   output logic [31:0]  q_ret_cnt
`endif
);

   state_e r_state;
   pc_t    r_pc;
   logic   r_ce_fetch;
   logic   r_ce_dec;
   logic   r_ce_alu;
   logic   r_busy;
   logic   r_halted;
   logic   r_err;

   // A stop request is only honoured where the sequencer would start a new
   // fetch, so the instruction in flight always finishes first.
   state_e w_next_fetch;
   logic   w_go_fetch;
   assign w_go_fetch   = bus.i_run;
   assign w_next_fetch = bus.i_run ? S_FETCH : S_IDLE;

   // Sequencer FSM; enables and status are registered alongside the state so
   // they line up exactly with the state they describe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= PC_RESET;
         r_ce_fetch <= 1'b0;
         r_ce_dec   <= 1'b0;
         r_ce_alu   <= 1'b0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ce_fetch <= 1'b0;
         r_ce_dec   <= 1'b0;
         r_ce_alu   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_run) begin
                  r_pc       <= PC_RESET;
                  r_err      <= 1'b0;
                  r_state    <= S_FETCH;
                  r_ce_fetch <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_FETCH: r_state <= S_FWAIT;
            S_FWAIT: begin
               if (bus.i_imem_rdy) begin
                  r_state  <= S_DECODE;
                  r_ce_dec <= 1'b1;
               end
            end
            S_DECODE: begin
               if (bus.i_dec_halt) begin
                  r_state  <= S_HALT;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else begin
                  r_state  <= S_EXEC;
                  r_ce_alu <= 1'b1;
               end
            end
            S_EXEC: r_state <= S_ALU;
            S_ALU: begin
               // Branch outranks RAM, RAM outranks register write-back.
               if (bus.i_alu_branch) begin
                  r_pc       <= bus.i_alu_result;
                  r_state    <= w_next_fetch;
                  r_ce_fetch <= w_go_fetch;
                  r_busy     <= w_go_fetch;
               end else if (bus.i_alu_ce_ram) begin
                  r_pc    <= pc_inc(r_pc);
                  r_state <= S_MEM;
               end else if (bus.i_alu_ce_reg) begin
                  r_pc       <= pc_inc(r_pc);
                  r_state    <= w_next_fetch;
                  r_ce_fetch <= w_go_fetch;
                  r_busy     <= w_go_fetch;
               end else begin
                  r_err    <= 1'b1;
                  r_state  <= S_HALT;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end
            end
            S_MEM: begin
               if (bus.i_ram_done) begin
                  r_state    <= w_next_fetch;
                  r_ce_fetch <= w_go_fetch;
                  r_busy     <= w_go_fetch;
               end
            end
            S_HALT: begin
               if (!bus.i_run) begin
                  r_state  <= S_IDLE;
                  r_halted <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_busy   <= 1'b0;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   assign bus.q_pc       = r_pc;
   assign bus.q_ce_fetch = r_ce_fetch;
   assign bus.q_ce_dec   = r_ce_dec;
   assign bus.q_ce_alu   = r_ce_alu;
   assign bus.q_busy     = r_busy;
   assign bus.q_halted   = r_halted;
   assign bus.q_err      = r_err;

`ifdef PRCO_PIPE_PERF_EN
   // An instruction retires when S_ALU completes without RAM or error, or
   // when S_MEM completes.
   logic w_retire;
   logic w_clr;
   assign w_retire = ((r_state == S_ALU) &&
                      (bus.i_alu_branch || (!bus.i_alu_ce_ram && bus.i_alu_ce_reg))) ||
                     ((r_state == S_MEM) && bus.i_ram_done);
   assign w_clr    = (r_state == S_IDLE) && bus.i_run;

   prco_perf_cnt u_perf_cnt (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (w_clr),
      .i_busy    (r_busy),
      .i_retire  (w_retire),
      .q_cyc_cnt (q_cyc_cnt),
      .q_ret_cnt (q_ret_cnt)
   );
`endif

endmodule
